// File: rtl/blur_row_fetcher_if.sv
// Pixel-memory read port between the row fetcher (master) and pixel memory (slave).
// mem_read/mem_addr are held by the master until the slave returns mem_ready.
interface blur_row_fetcher_if #(
    parameter int ADDR_BITS = 20
);
    logic                 mem_read;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ready;
    logic [7:0]           mem_data;

    modport master (output mem_read, output mem_addr, input mem_ready, input mem_data);
    modport slave  (input mem_read, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/blur_row_fetcher.sv
// Walks 16-column anchors in raster order, fetches 20-pixel row segments into a
// buffer and hands each one to the blur stage, prefetching while blur is busy.
module blur_row_fetcher #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_BITS  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    blur_row_fetcher_if.master mem,
    output logic [19:0][7:0]   blur_in_o,
    output logic [31:0]        anchor_x_o,
    output logic [31:0]        anchor_y_o,
    output logic               anchor_moving_o,
    input  logic               blur_final_i,
    output logic               frame_done_o,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_DRAIN} state_e;

    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(IMG_WIDTH);

    state_e               state_q;
    logic [4:0]           slot_q;
    logic [31:0]          anchor_x_q, anchor_y_q;
    logic [ADDR_BITS-1:0] row_base_q;
    logic [19:0][7:0]     buf_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic [31:0]          col;
    logic                 col_in;
    logic                 issue;
    logic                 wrap;
    logic                 last_anchor;
    logic [31:0]          anchor_x_d, anchor_y_d;
    logic [ADDR_BITS-1:0] row_base_d;

    assign col    = anchor_x_q + 32'(slot_q);
    assign col_in = col < 32'(IMG_WIDTH);

    // Columns past the right edge are zero-filled without touching memory.
    assign mem.mem_read = (state_q == S_FETCH) && col_in;
    assign mem.mem_addr = row_base_q + col[ADDR_BITS-1:0];

    // Issue also in the cycle blur finishes, so back-to-back segments have no gap.
    assign issue = (state_q == S_READY) && (!busy_q || blur_final_i);

    assign wrap        = (anchor_x_q + 32'd16) >= 32'(IMG_WIDTH);
    assign last_anchor = wrap && (anchor_y_q == 32'(IMG_HEIGHT - 1));
    assign anchor_x_d  = wrap ? 32'd0 : anchor_x_q + 32'd16;
    assign anchor_y_d  = wrap ? anchor_y_q + 32'd1 : anchor_y_q;
    assign row_base_d  = wrap ? row_base_q + ROW_STEP : row_base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            slot_q       <= 5'd0;
            anchor_x_q   <= 32'd0;
            anchor_y_q   <= 32'd0;
            row_base_q   <= '0;
            buf_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (issue) begin
                busy_q <= 1'b1;
            end else if (blur_final_i) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        anchor_x_q <= 32'd0;
                        anchor_y_q <= 32'd0;
                        row_base_q <= '0;
                        slot_q     <= 5'd0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!col_in || mem.mem_ready) begin
                        buf_q[slot_q] <= col_in ? mem.mem_data : 8'd0;
                        if (slot_q == 5'd19) begin
                            state_q <= S_READY;
                        end else begin
                            slot_q <= slot_q + 5'd1;
                        end
                    end
                end
                S_READY: begin
                    if (issue) begin
                        anchor_x_q <= anchor_x_d;
                        anchor_y_q <= anchor_y_d;
                        row_base_q <= row_base_d;
                        slot_q     <= 5'd0;
                        state_q    <= last_anchor ? S_DRAIN : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (blur_final_i && busy_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign blur_in_o       = buf_q;
    assign anchor_x_o      = anchor_x_q;
    assign anchor_y_o      = anchor_y_q;
    assign anchor_moving_o = issue;
    assign frame_done_o    = frame_done_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_blur_row_fetcher.sv
// Bench for blur_row_fetcher: two instances (40x1 and 32x2 frames), a pixel
// memory returning addr[7:0], table-driven frame runs and hand-written corner cases.
module tb_blur_row_fetcher;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_a, start_b, bf_a, bf_b;
    int   wait_mode = 0;
    int   wcnt_a = 0, wcnt_b = 0;
    int   sel = 0;
    int   n_vec = 0, n_err = 0;

    blur_row_fetcher_if #(.ADDR_BITS(12)) mif_a ();
    blur_row_fetcher_if #(.ADDR_BITS(12)) mif_b ();

    logic [19:0][7:0] bin_a, bin_b;
    logic [31:0]      ax_a, ay_a, ax_b, ay_b;
    logic             am_a, am_b, fd_a, fd_b;
    logic [1:0]       st_a, st_b;

    blur_row_fetcher #(.IMG_WIDTH(40), .IMG_HEIGHT(1), .ADDR_BITS(12)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .mem(mif_a.master),
        .blur_in_o(bin_a), .anchor_x_o(ax_a), .anchor_y_o(ay_a),
        .anchor_moving_o(am_a), .blur_final_i(bf_a), .frame_done_o(fd_a), .state_o(st_a));

    blur_row_fetcher #(.IMG_WIDTH(32), .IMG_HEIGHT(2), .ADDR_BITS(12)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .mem(mif_b.master),
        .blur_in_o(bin_b), .anchor_x_o(ax_b), .anchor_y_o(ay_b),
        .anchor_moving_o(am_b), .blur_final_i(bf_b), .frame_done_o(fd_b), .state_o(st_b));

    // Pixel memory: data = address low byte; in wait mode every slot takes 3 cycles.
    assign mif_a.mem_data  = mif_a.mem_addr[7:0];
    assign mif_b.mem_data  = mif_b.mem_addr[7:0];
    assign mif_a.mem_ready = mif_a.mem_read && (wait_mode == 0 || wcnt_a == 2);
    assign mif_b.mem_ready = mif_b.mem_read && (wait_mode == 0 || wcnt_b == 2);
    always @(posedge clk) begin
        wcnt_a <= (mif_a.mem_read && !mif_a.mem_ready) ? wcnt_a + 1 : 0;
        wcnt_b <= (mif_b.mem_read && !mif_b.mem_ready) ? wcnt_b + 1 : 0;
    end

    logic             v_rd, v_rdy, v_am, v_fd;
    logic [11:0]      v_addr;
    logic [31:0]      v_ax, v_ay;
    logic [19:0][7:0] v_bin;
    logic [1:0]       v_st;
    always_comb begin
        v_rd = mif_a.mem_read; v_rdy = mif_a.mem_ready; v_addr = mif_a.mem_addr;
        v_am = am_a; v_fd = fd_a; v_ax = ax_a; v_ay = ay_a; v_bin = bin_a; v_st = st_a;
        if (sel != 0) begin
            v_rd = mif_b.mem_read; v_rdy = mif_b.mem_ready; v_addr = mif_b.mem_addr;
            v_am = am_b; v_fd = fd_b; v_ax = ax_b; v_ay = ay_b; v_bin = bin_b; v_st = st_b;
        end
    end

    typedef struct {
        int sel; int wmode; int bf_delay; int n_issue; int exp_reads; int done_cyc;
    } frame_t;
    typedef struct {
        int frame; int cyc; int x; int y; int first_addr; int valid;
    } issue_t;

    frame_t frames [3];
    issue_t issues [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_bf(input logic v);
        if (sel == 0) bf_a = v; else bf_b = v;
    endtask

    task automatic run_frame(input int f);
        int cyc, bf_at, n_iss, n_fd, done_cyc, reads, stab_err, seg, i;
        logic prev_wait;
        logic [11:0] prev_addr;
        logic got_first [8];
        int first_addr [8];
        int rc [8], rx [8], ry [8];
        logic [19:0][7:0] rp [8];
        sel = frames[f].sel;
        wait_mode = frames[f].wmode;
        n_iss = 0; n_fd = 0; done_cyc = -1; reads = 0; stab_err = 0; bf_at = -1;
        prev_wait = 1'b0; prev_addr = '0;
        for (int k = 0; k < 8; k++) begin
            got_first[k] = 1'b0; first_addr[k] = -1;
            rc[k] = 0; rx[k] = 0; ry[k] = 0; rp[k] = '0;
        end
        @(negedge clk);
        cyc = 0;
        set_start(1'b1);
        while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 5)) begin
            @(negedge clk);
            cyc++;
            set_start(1'b0);
            set_bf(cyc == bf_at);
            #1;
            seg = (n_iss < 8) ? n_iss : 7;
            if (v_rd && !got_first[seg]) begin
                got_first[seg] = 1'b1;
                first_addr[seg] = int'(v_addr);
            end
            if (prev_wait && (!v_rd || v_addr !== prev_addr)) stab_err++;
            prev_wait = v_rd && !v_rdy;
            prev_addr = v_addr;
            if (v_rd && v_rdy) reads++;
            if (v_am) begin
                if (n_iss < 8) begin
                    rc[n_iss] = cyc; rx[n_iss] = int'(v_ax); ry[n_iss] = int'(v_ay);
                    rp[n_iss] = v_bin;
                end
                n_iss++;
                bf_at = cyc + frames[f].bf_delay;
            end
            if (v_fd) begin
                n_fd++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        set_bf(1'b0);
        chk($sformatf("f%0d_issue_count", f), 64'(n_iss), 64'(frames[f].n_issue));
        chk($sformatf("f%0d_frame_done_cycle", f), 64'(done_cyc), 64'(frames[f].done_cyc));
        chk($sformatf("f%0d_frame_done_pulses", f), 64'(n_fd), 64'd1);
        chk($sformatf("f%0d_read_count", f), 64'(reads), 64'(frames[f].exp_reads));
        chk($sformatf("f%0d_addr_stable_errs", f), 64'(stab_err), 64'd0);
        i = 0;
        for (int j = 0; j < 10; j++) begin
            if (issues[j].frame == f) begin
                if (i < n_iss && i < 8) begin
                    chk($sformatf("f%0d_i%0d_cycle", f, i), 64'(rc[i]), 64'(issues[j].cyc));
                    chk($sformatf("f%0d_i%0d_x", f, i), 64'(rx[i]), 64'(issues[j].x));
                    chk($sformatf("f%0d_i%0d_y", f, i), 64'(ry[i]), 64'(issues[j].y));
                    chk($sformatf("f%0d_i%0d_first_addr", f, i), 64'(first_addr[i]),
                        64'(issues[j].first_addr));
                    for (int k = 0; k < 20; k++) begin
                        chk($sformatf("f%0d_i%0d_slot%0d", f, i, k), 64'(rp[i][k]),
                            (k < issues[j].valid) ? 64'((issues[j].first_addr + k) & 255) : 64'd0);
                    end
                end
                i++;
            end
        end
    endtask

    initial begin
        int am_seen;
        frames[0] = '{0, 0, 5, 3, 48, 69};
        frames[1] = '{0, 1, 5, 3, 48, 165};
        frames[2] = '{1, 0, 5, 4, 72, 90};
        issues[0] = '{0, 21,  0, 0,  0, 20};
        issues[1] = '{0, 42, 16, 0, 16, 20};
        issues[2] = '{0, 63, 32, 0, 32,  8};
        issues[3] = '{1, 61,  0, 0,  0, 20};
        issues[4] = '{1, 122, 16, 0, 16, 20};
        issues[5] = '{1, 159, 32, 0, 32,  8};
        issues[6] = '{2, 21,  0, 0,  0, 20};
        issues[7] = '{2, 42, 16, 0, 16, 16};
        issues[8] = '{2, 63,  0, 1, 32, 20};
        issues[9] = '{2, 84, 16, 1, 48, 16};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bf_a = 1'b0; bf_b = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_mem_read", s), 64'(v_rd), 64'd0);
            chk($sformatf("rst%0d_mem_addr", s), 64'(v_addr), 64'd0);
            chk($sformatf("rst%0d_anchor_x", s), 64'(v_ax), 64'd0);
            chk($sformatf("rst%0d_anchor_y", s), 64'(v_ay), 64'd0);
            chk($sformatf("rst%0d_anchor_moving", s), 64'(v_am), 64'd0);
            chk($sformatf("rst%0d_frame_done", s), 64'(v_fd), 64'd0);
            chk($sformatf("rst%0d_blur_in_nonzero", s), 64'(|v_bin), 64'd0);
            chk($sformatf("rst%0d_state", s), 64'(v_st), 64'(ST_IDLE));
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        wait_mode = 0;

        // Single segment with blur_final held low, then a same-cycle reissue.
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            #1;
            if (c == 20) chk("single_no_issue_c20", 64'(v_am), 64'd0);
        end
        chk("single_issue_c21", 64'(v_am), 64'd1);
        chk("single_anchor_x", 64'(v_ax), 64'd0);
        chk("single_anchor_y", 64'(v_ay), 64'd0);
        for (int k = 0; k < 20; k++) chk($sformatf("single_slot%0d", k), 64'(v_bin[k]), 64'(k));
        am_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (v_am) am_seen++;
        end
        chk("held_no_issue", 64'(am_seen), 64'd0);
        chk("held_state_ready", 64'(v_st), 64'(ST_READY));
        chk("prefetch_slot0", 64'(v_bin[0]), 64'd16);
        chk("prefetch_slot19", 64'(v_bin[19]), 64'd35);
        @(negedge clk);
        bf_a = 1'b1;
        #1;
        chk("b2b_issue_same_cycle", 64'(v_am), 64'd1);
        chk("b2b_anchor_x", 64'(v_ax), 64'd16);
        @(negedge clk);
        bf_a = 1'b0;

        // Asynchronous reset in the middle of the x=32 fetch.
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_mem_read", 64'(v_rd), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_read", 64'(v_rd), 64'd0);
        chk("async_rst_mem_addr", 64'(v_addr), 64'd0);
        chk("async_rst_anchor_x", 64'(v_ax), 64'd0);
        chk("async_rst_state", 64'(v_st), 64'(ST_IDLE));
        chk("async_rst_blur_in_nonzero", 64'(|v_bin), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int f = 0; f < 3; f++) run_frame(f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/blur_row_fetcher.md
# blur_row_fetcher

Upstream feeder for the blur stage. Walks the anchor in raster order over the frame in 16-column steps. For each anchor it reads a 20-pixel row segment from pixel memory and presents it on `blur_in`. It pulses `anchor_moving` so the blur controller copies the segment, and it prefetches the next segment while blur processes the current one.

## Interface
- `IMG_WIDTH`, default 640: frame width in pixels; must be ≥16.
- `IMG_HEIGHT`, default 480: frame height in rows; must be ≥1.
- `ADDR_BITS`, default 20: pixel memory address width; must satisfy IMG_WIDTH·IMG_HEIGHT ≤ 2^ADDR_BITS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- `mem_read` out 1: read request to pixel memory.
- `mem_addr` out ADDR_BITS: pixel address, anchor_y·IMG_WIDTH + column.
- `mem_ready` in 1: `mem_data` valid for the current request.
- `mem_data` in 8: pixel read data.
- `blur_in` out 8 × [20]: current row segment; slot k = column anchor_x+k.
- `anchor_x`, `anchor_y` out 32 each: coordinates of the segment on `blur_in`.
- `anchor_moving` out 1: segment ready; the blur stage copies `blur_in` in this cycle.
- `blur_final` in 1: the blur stage finished its current segment.
- `frame_done` out 1: one-cycle pulse after the blur stage finishes the last anchor.

## Operation
- States:
  - IDLE: waits for `start`.
  - FETCH: fills the buffer.
  - READY: buffer full, waiting to issue.
  - DRAIN: last segment issued, waiting for blur to finish.
- IDLE + `start`: anchor := (0,0), slot := 0, then FETCH.
- FETCH, slot k (0..19), column c = anchor_x+k:
  - c < IMG_WIDTH: hold `mem_read`=1 with `mem_addr` stable until `mem_ready`. On that cycle, `blur_in[k]` := `mem_data` and k advances.
  - c ≥ IMG_WIDTH: `blur_in[k]` := 0 with no read, one cycle per slot.
  - After slot 19 is written, go to READY.
- `busy` flag: set when `anchor_moving` fires; cleared when `blur_final`=1 and `anchor_moving`=0.
- In READY, `anchor_moving` = !busy || blur_final (combinational). This allows back-to-back issue in the cycle blur finishes.
- On the `anchor_moving` cycle:
  - anchor_x += 16.
  - If anchor_x+16 ≥ IMG_WIDTH: anchor_x := 0 and anchor_y += 1.
  - If this was the last anchor (anchor_y = IMG_HEIGHT−1 and anchor_x+16 ≥ IMG_WIDTH), go to DRAIN. Otherwise go to FETCH with slot := 0.
- `blur_in` is written only in FETCH, so it is stable from READY entry through the `anchor_moving` cycle.
- DRAIN + `blur_final`: `frame_done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `mem_ready` while `mem_read`=0 is ignored.
- `blur_final` while not busy is ignored.
- Address arithmetic: a row base register adds IMG_WIDTH per row, and the column offset is added to it. No multiplier. Truncate to ADDR_BITS.

## Timing
- Reset values:
  - `mem_read`=0, `mem_addr`=0.
  - `blur_in` all 0.
  - `anchor_x`=`anchor_y`=0.
  - `anchor_moving`=0, `frame_done`=0.
  - busy=0, state IDLE.
- Reset mid-operation: all of the above take effect immediately. `mem_read` drops asynchronously, and no pending read is completed.
- `mem_ready` may be high in the same cycle `mem_read` rises (zero-wait). With zero-wait memory, a full in-image fetch is 20 cycles.
- Start latency with zero-wait memory: `start` at cycle 0 → FETCH cycles 1–20 → READY and `anchor_moving` at cycle 21.
- `mem_read` may stay high across consecutive slots; `mem_addr` changes only the cycle after `mem_ready`.
- `frame_done` asserts the cycle after `blur_final` is sampled in DRAIN.

## Test plan
- **Single segment.** IMG_WIDTH=40, IMG_HEIGHT=1, zero-wait memory, mem[a]=a, `blur_final` tied 0 → after `start`:
  - First `anchor_moving` at cycle 21 with `blur_in[k]`=k and anchor (0,0).
  - Second fetch completes but does not issue.
- **Right-edge zero padding.** IMG_WIDTH=40; drive `blur_final` 5 cycles after each issue → anchor x=32 segment: slots 0–7 = 32..39, slots 8–19 = 0.
  - Only 8 reads are issued for that segment.
  - Total issues = 3, then `frame_done` pulses once.
- **Wait states.** `mem_ready` every 3rd cycle → `mem_addr` stays stable while waiting, captured data is correct, and the segment takes 60 cycles.
- **Back-to-back issue.** Buffer READY and `blur_final`=1 in the same cycle → `anchor_moving`=1 in that cycle, with no idle gap.
- **Row wrap.** IMG_WIDTH=32, IMG_HEIGHT=2 → anchors issue in order (0,0), (16,0), (0,1), (16,1). At (0,1) `mem_addr` starts at 32.
- **Reset.** Assert `rst` mid-FETCH with `mem_read`=1 → `mem_read`=0 immediately and outputs take reset values. A new `start` restarts at anchor (0,0).
